vga_line_fetcher: RTL and testbench
===================================

Name: vga_line_fetcher

Overview:
- Upstream feeder for the VGA scan-out stage.
- Watches the scan-out's fetch request (enable, 32-pixel x-group, line y) and reads the 32 matching 12-bit BGR pixels from framebuffer memory through an in-order pipelined read port.
- Assembles the pixels in a shadow buffer, then commits all 32 at once to the output buffer that scan-out samples.
- Sits between the memory arbiter and the VGA timing/scan-out block, in the same clk domain.

Parameters:
- ADDR_W, 19, memory word address width.
- DATA_W, 16, memory read data width; pixel is bits [11:0] (B[11:8], G[7:4], R[3:0]).
- FB_BASE, 0, framebuffer base word address.
- LINE_WORDS, 640, words per framebuffer line (one pixel per word).
- MAX_OUTSTANDING, 4, maximum accepted-but-unreturned reads.

Ports:
- clk  in  1  system clock (50 MHz).
- rst  in  1  asynchronous active-low reset.
- fetch_en  in  1  scan-out requests data for the current group.
- fetch_x_group  in  5  group index 0..19 (32 pixels each).
- fetch_y_val  in  9  line 0..479.
- mem_rd_req  out  1  read request.
- mem_rd_addr  out  ADDR_W  read word address.
- mem_rd_gnt  in  1  request accepted this cycle when req&gnt.
- mem_rd_valid  in  1  read data returning, in request order.
- mem_rd_data  in  DATA_W  read data.
- bgr_buf  out  32x12  committed pixels; index i = pixel group*32+i.
- buf_x_group  out  5  group of the committed buffer.
- buf_y_val  out  9  line of the committed buffer.
- buf_commit  out  1  one-cycle pulse when bgr_buf updates.
- overrun  out  1  sticky: a request was dropped.

Behaviour:
- Reset (rst=0, async): bgr_buf all 0, buf_x_group 0, buf_y_val 0, buf_commit 0, overrun 0, mem_rd_req 0, state IDLE.
- All tracking fields are cleared: last tuple invalid, pending 0, counters 0.
- Data returning after reset release for pre-reset requests is not expected. The arbiter shares rst.
- Trigger: fetch_en=1 and (fetch_y_val, fetch_x_group) ≠ last started tuple, or last tuple invalid. The tuple is latched as the target.
- Address for pixel i = FB_BASE + y*LINE_WORDS + group*32 + i, computed at ADDR_W bits, truncated; i = 0..31.
- States:
  - IDLE: on trigger -> FETCH, issue_cnt=0, recv_cnt=0.
  - FETCH: mem_rd_req=1 while issue_cnt<32 and (issue_cnt-recv_cnt)<MAX_OUTSTANDING.
    - mem_rd_addr is valid with req and held stable until gnt. issue_cnt increments on req&gnt.
    - Each mem_rd_valid writes mem_rd_data[11:0] into shadow[recv_cnt]; recv_cnt increments.
    - When issue_cnt=32 -> DRAIN.
  - DRAIN: req=0; accept returns; when recv_cnt=32 (including the return arriving that cycle) -> COMMIT.
  - COMMIT: one cycle.
    - Copy shadow to bgr_buf; set buf_x_group/buf_y_val = target; buf_commit=1.
    - If pending -> load pending tuple, clear pending, go to FETCH; else -> IDLE.
- A new trigger seen in FETCH/DRAIN/COMMIT is stored as pending; the in-flight fetch is never aborted.
- A trigger while pending is already occupied by a different tuple replaces pending and sets overrun=1 (sticky until reset).
- fetch_en deasserting mid-fetch does not abort; the fetch completes and commits.
- Same-cycle req&gnt and rd_valid both counted. Outstanding never exceeds MAX_OUTSTANDING.
- rd_valid in IDLE is ignored.
- Latency: commit occurs ≥ 32 + read latency cycles after trigger; with 1-cycle memory latency and gnt always high, commit is at trigger+34.
- Last tuple is only invalidated by reset. Re-requesting the same tuple after commit does not refetch.

Decomposition:
- Shared package vga_pkg:
  - typedef pixel_t (logic [11:0]).
  - typedef pix_buf_t (pixel_t [31:0]).
  - constants PIXELS_PER_GROUP=32, ACTIVE_W=640, ACTIVE_H=480, GROUPS_PER_LINE=20.
  - state enum fetch_state_t {IDLE, FETCH, DRAIN, COMMIT}.
- One sub-module, vga_fetch_addr_gen: registered target tuple plus issue_cnt -> mem_rd_addr. It is the multiply-by-LINE_WORDS path, kept as shift-add (y<<9 + y<<7).

Test Plan:
- Trigger y=0, group=0, gnt=1, 1-cycle memory returning addr as data -> addresses 0..31, bgr_buf[i]=i, buf_commit at trigger+34, overrun=0.
- y=479, group=19, FB_BASE=0 -> first addr 307168, last 307199; buf_y_val=479, buf_x_group=19.
- gnt toggled 1/0 and memory latency 6 -> outstanding never >4, addr held while gnt=0, all 32 pixels in order. Data 0xABC on each word -> every bgr_buf entry 0xABC.
- New tuple (y=1, g=0) mid-FETCH of (0,0) -> (0,0) commits first, then (1,0) fetches immediately; two buf_commit pulses; overrun=0.
- Two distinct new tuples during one fetch -> only the latest is fetched after commit; overrun=1 and stays 1.
- rst pulsed low mid-FETCH (issue_cnt=10) -> outputs 0 immediately (async), req=0; after release, re-trigger of the same tuple fetches again.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA line fetch and scan-out path.
package vga_pkg;

    typedef logic [11:0] pixel_t;
    typedef pixel_t [31:0] pix_buf_t;

    localparam int PIXELS_PER_GROUP = 32;
    localparam int ACTIVE_W         = 640;
    localparam int ACTIVE_H         = 480;
    localparam int GROUPS_PER_LINE  = 20;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, COMMIT} fetch_state_t;

endpackage

// File: rtl/vga_fetch_addr_gen.sv
// Holds the target (line, group) of the fetch in flight and turns it plus the
// pixel index into a framebuffer word address.
module vga_fetch_addr_gen #(
    parameter int ADDR_W     = 19,
    parameter int FB_BASE    = 0,
    parameter int LINE_WORDS = 640
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [8:0]        load_y,
    input  logic [4:0]        load_group,
    input  logic [4:0]        pixel_idx,
    output logic [8:0]        target_y,
    output logic [4:0]        target_group,
    output logic [ADDR_W-1:0] addr
);

    logic [ADDR_W-1:0] y_ext;
    logic [ADDR_W-1:0] line_off;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            target_y     <= '0;
            target_group <= '0;
        end else if (load) begin
            target_y     <= load_y;
            target_group <= load_group;
        end
    end

    assign y_ext = ADDR_W'(target_y);

    // 640 = 512 + 128, so the line offset needs no multiplier for the native mode.
    assign line_off = (LINE_WORDS == 640) ? ((y_ext << 9) + (y_ext << 7))
                                          : (y_ext * ADDR_W'(LINE_WORDS));

    assign addr = ADDR_W'(FB_BASE) + line_off + (ADDR_W'(target_group) << 5)
                + ADDR_W'(pixel_idx);

endmodule

// File: rtl/vga_line_fetcher.sv
// Fetches one 32-pixel group of a line from framebuffer memory into a shadow
// buffer, then commits it atomically to the buffer the scan-out samples.
module vga_line_fetcher
    import vga_pkg::*;
#(
    parameter int ADDR_W          = 19,
    parameter int DATA_W          = 16,
    parameter int FB_BASE         = 0,
    parameter int LINE_WORDS      = 640,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_en,
    input  logic [4:0]        fetch_x_group,
    input  logic [8:0]        fetch_y_val,
    output logic              mem_rd_req,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic              mem_rd_gnt,
    input  logic              mem_rd_valid,
    input  logic [DATA_W-1:0] mem_rd_data,
    output pix_buf_t          bgr_buf,
    output logic [4:0]        buf_x_group,
    output logic [8:0]        buf_y_val,
    output logic              buf_commit,
    output logic              overrun,
    output fetch_state_t      fsm_state
);

    localparam logic [5:0] GROUP_PIX = 6'(PIXELS_PER_GROUP);
    localparam logic [5:0] MAX_OUT   = 6'(MAX_OUTSTANDING);

    fetch_state_t state, state_next;
    logic [5:0]   issue_cnt, recv_cnt, outstanding;
    pix_buf_t     shadow;
    logic         last_valid, pend_valid;
    logic [8:0]   last_y, pend_y, tgt_y, load_y, pend_eff_y;
    logic [4:0]   last_group, pend_group, tgt_group, load_group, pend_eff_group;
    logic         trigger, pend_hit, pend_eff_valid, load;
    logic         issue, accept, recv_done;
    logic         unused_data_bits;

    assign unused_data_bits = ^mem_rd_data[DATA_W-1:12];

    assign trigger = fetch_en && (!last_valid || fetch_y_val != last_y
                                  || fetch_x_group != last_group);

    // A trigger arriving in the same cycle as a commit supersedes the stored one.
    assign pend_hit       = trigger && (state != IDLE);
    assign pend_eff_valid = pend_valid || pend_hit;
    assign pend_eff_y     = pend_hit ? fetch_y_val : pend_y;
    assign pend_eff_group = pend_hit ? fetch_x_group : pend_group;

    // Read port: an address is offered while mem_rd_req is high and must stay
    // put until the cycle mem_rd_gnt is also high, which is the transfer;
    // data then returns in order, one word per mem_rd_valid cycle.
    assign outstanding = issue_cnt - recv_cnt;
    assign mem_rd_req  = (state == FETCH) && (issue_cnt < GROUP_PIX) && (outstanding < MAX_OUT);
    assign issue       = mem_rd_req && mem_rd_gnt;
    assign accept      = mem_rd_valid && (state == FETCH || state == DRAIN) && !recv_cnt[5];
    assign recv_done   = (recv_cnt + 6'(accept)) == GROUP_PIX;
    assign fsm_state   = state;

    vga_fetch_addr_gen #(
        .ADDR_W    (ADDR_W),
        .FB_BASE   (FB_BASE),
        .LINE_WORDS(LINE_WORDS)
    ) u_addr_gen (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .load_y      (load_y),
        .load_group  (load_group),
        .pixel_idx   (issue_cnt[4:0]),
        .target_y    (tgt_y),
        .target_group(tgt_group),
        .addr        (mem_rd_addr)
    );

    always_comb begin
        state_next = state;
        load       = 1'b0;
        load_y     = fetch_y_val;
        load_group = fetch_x_group;
        case (state)
            IDLE: if (trigger) begin
                load       = 1'b1;
                state_next = FETCH;
            end
            FETCH: if (issue_cnt == GROUP_PIX) state_next = DRAIN;
            DRAIN: if (recv_done) state_next = COMMIT;
            COMMIT: begin
                if (pend_eff_valid) begin
                    load       = 1'b1;
                    load_y     = pend_eff_y;
                    load_group = pend_eff_group;
                    state_next = FETCH;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            issue_cnt   <= '0;
            recv_cnt    <= '0;
            shadow      <= '0;
            last_valid  <= 1'b0;
            last_y      <= '0;
            last_group  <= '0;
            pend_valid  <= 1'b0;
            pend_y      <= '0;
            pend_group  <= '0;
            bgr_buf     <= '0;
            buf_x_group <= '0;
            buf_y_val   <= '0;
            buf_commit  <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state      <= state_next;
            buf_commit <= (state_next == COMMIT);

            if (load) begin
                issue_cnt  <= '0;
                recv_cnt   <= '0;
                last_valid <= 1'b1;
                last_y     <= load_y;
                last_group <= load_group;
            end else begin
                if (issue) issue_cnt <= issue_cnt + 6'd1;
                if (accept) begin
                    shadow[recv_cnt[4:0]] <= mem_rd_data[11:0];
                    recv_cnt              <= recv_cnt + 6'd1;
                end
            end

            if (state == COMMIT) begin
                pend_valid <= 1'b0;
            end else if (pend_hit) begin
                pend_valid <= 1'b1;
                pend_y     <= fetch_y_val;
                pend_group <= fetch_x_group;
            end
            if (pend_hit && pend_valid && (fetch_y_val != pend_y || fetch_x_group != pend_group))
                overrun <= 1'b1;

            // The final return may land on the same edge as the commit, so merge it here.
            if (state == DRAIN && recv_done) begin
                for (int i = 0; i < PIXELS_PER_GROUP; i++)
                    bgr_buf[i] <= (accept && recv_cnt[4:0] == 5'(i)) ? mem_rd_data[11:0] : shadow[i];
                buf_x_group <= tgt_group;
                buf_y_val   <= tgt_y;
            end
        end
    end

endmodule

// File: tb/tb_vga_line_fetcher.sv
// Directed bench for vga_line_fetcher with an in-order memory responder model.
module tb_vga_line_fetcher;
    import vga_pkg::*;

    localparam int ADDR_W = 19;
    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              fetch_en = 1'b0;
    logic [4:0]        fetch_x_group = '0;
    logic [8:0]        fetch_y_val = '0;
    logic              mem_rd_req;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic              mem_rd_gnt = 1'b0;
    logic              mem_rd_valid = 1'b0;
    logic [DATA_W-1:0] mem_rd_data = '0;
    pix_buf_t          bgr_buf;
    logic [4:0]        buf_x_group;
    logic [8:0]        buf_y_val;
    logic              buf_commit;
    logic              overrun;
    fetch_state_t      fsm_state;

    vga_line_fetcher dut (
        .clk          (clk),
        .rst          (rst),
        .fetch_en     (fetch_en),
        .fetch_x_group(fetch_x_group),
        .fetch_y_val  (fetch_y_val),
        .mem_rd_req   (mem_rd_req),
        .mem_rd_addr  (mem_rd_addr),
        .mem_rd_gnt   (mem_rd_gnt),
        .mem_rd_valid (mem_rd_valid),
        .mem_rd_data  (mem_rd_data),
        .bgr_buf      (bgr_buf),
        .buf_x_group  (buf_x_group),
        .buf_y_val    (buf_y_val),
        .buf_commit   (buf_commit),
        .overrun      (overrun),
        .fsm_state    (fsm_state)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Memory responder state
    int                mem_lat = 1;
    bit                gnt_toggle = 1'b0;
    bit                data_abc = 1'b0;
    logic [ADDR_W-1:0] ret_addr[$];
    int                ret_due[$];
    logic [ADDR_W-1:0] acc_q[$];
    int                mem_cyc = 0;
    bit                waiting = 1'b0;
    logic [ADDR_W-1:0] held_addr = '0;
    int                hold_err = 0;
    int                ovf_err = 0;

    // Scoreboard of expected committed tuples {y, group}
    logic [13:0] exp_q[$];

    typedef struct {
        logic [8:0]  y;
        logic [4:0]  g;
        int          lat;
        bit          toggle;
        bit          abc;
        int          first;
        int          last;
        logic [11:0] pix0;
        logic [11:0] pix31;
        int          exp_n;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Memory model: drives gnt/valid/data on negedges, returns data mem_lat edges after accept.
    initial begin
        forever begin
            @(negedge clk);
            mem_cyc++;
            if (!rst) begin
                ret_addr.delete();
                ret_due.delete();
                mem_rd_valid = 1'b0;
                mem_rd_gnt   = 1'b0;
                waiting      = 1'b0;
            end else begin
                if (ret_due.size() > 0 && ret_due[0] <= mem_cyc) begin
                    mem_rd_valid = 1'b1;
                    mem_rd_data  = data_abc ? 16'h0ABC : 16'(ret_addr[0]);
                    void'(ret_addr.pop_front());
                    void'(ret_due.pop_front());
                end else begin
                    mem_rd_valid = 1'b0;
                end
                if (waiting && (!mem_rd_req || mem_rd_addr != held_addr)) hold_err++;
                mem_rd_gnt = gnt_toggle ? ~mem_rd_gnt : 1'b1;
                if (mem_rd_req && mem_rd_gnt) begin
                    ret_addr.push_back(mem_rd_addr);
                    ret_due.push_back(mem_cyc + mem_lat);
                    acc_q.push_back(mem_rd_addr);
                end
                waiting   = mem_rd_req && !mem_rd_gnt;
                held_addr = mem_rd_addr;
                if (ret_due.size() > 4) ovf_err++;
            end
        end
    end

    task automatic pulse_fetch(input logic [8:0] y, input logic [4:0] g);
        fetch_y_val   = y;
        fetch_x_group = g;
        fetch_en      = 1'b1;
        @(negedge clk);
        fetch_en = 1'b0;
    endtask

    // Counts negedges until buf_commit is seen; the first negedge also drops fetch_en.
    task automatic wait_commit(input string name, input int bound, output int n);
        bit seen = 1'b0;
        n = 0;
        while (n < bound && !seen) begin
            @(negedge clk);
            n++;
            fetch_en = 1'b0;
            if (buf_commit) seen = 1'b1;
        end
        check({name, "_commit_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic check_commit(input string name, input int first, input bit abc);
        logic [13:0] exp_t;
        int bad = 0;
        exp_t = (exp_q.size() > 0) ? exp_q.pop_front() : 14'h3FFF;
        check({name, "_buf_y"}, 32'(buf_y_val), 32'(exp_t[13:5]));
        check({name, "_buf_x"}, 32'(buf_x_group), 32'(exp_t[4:0]));
        for (int i = 0; i < 32; i++) begin
            logic [11:0] want;
            want = abc ? 12'hABC : 12'(first + i);
            if (bgr_buf[i] !== want) bad++;
        end
        check({name, "_pixels_bad"}, 32'(bad), 32'd0);
    endtask

    task automatic check_addrs(input string name, input int first, input int last);
        int bad = 0;
        check({name, "_acc_count"}, 32'(acc_q.size()), 32'd32);
        check({name, "_first_addr"}, (acc_q.size() > 0) ? 32'(acc_q[0]) : 32'hFFFF_FFFF, 32'(first));
        check({name, "_last_addr"}, (acc_q.size() > 0) ? 32'(acc_q[acc_q.size()-1]) : 32'hFFFF_FFFF, 32'(last));
        for (int i = 1; i < acc_q.size(); i++)
            if (acc_q[i] != acc_q[i-1] + 1'b1) bad++;
        check({name, "_addr_seq_bad"}, 32'(bad), 32'd0);
    endtask

    initial begin
        int n;
        int commits;
        int bad;

        vecs[0] = '{y: 9'd0,   g: 5'd0,  lat: 1, toggle: 1'b0, abc: 1'b0, first: 0,
                    last: 31,     pix0: 12'h000, pix31: 12'h01F, exp_n: 35};
        vecs[1] = '{y: 9'd479, g: 5'd19, lat: 1, toggle: 1'b0, abc: 1'b0, first: 307168,
                    last: 307199, pix0: 12'hFE0, pix31: 12'hFFF, exp_n: 35};
        vecs[2] = '{y: 9'd2,   g: 5'd5,  lat: 6, toggle: 1'b1, abc: 1'b1, first: 1440,
                    last: 1471,   pix0: 12'hABC, pix31: 12'hABC, exp_n: 0};
        vecs[3] = '{y: 9'd100, g: 5'd10, lat: 3, toggle: 1'b0, abc: 1'b0, first: 64320,
                    last: 64351,  pix0: 12'hB40, pix31: 12'hB5F, exp_n: 0};

        // Reset
        #5 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_req", 32'(mem_rd_req), 32'd0);
        check("rst_commit", 32'(buf_commit), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_buf_y", 32'(buf_y_val), 32'd0);
        check("rst_buf_x", 32'(buf_x_group), 32'd0);
        check("rst_state", 32'(fsm_state), 32'(IDLE));
        bad = 0;
        for (int i = 0; i < 32; i++) if (bgr_buf[i] !== 12'h000) bad++;
        check("rst_bgr_nonzero", 32'(bad), 32'd0);
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);

        // Table-driven single fetches
        for (int v = 0; v < 4; v++) begin
            mem_lat    = vecs[v].lat;
            gnt_toggle = vecs[v].toggle;
            data_abc   = vecs[v].abc;
            acc_q.delete();
            exp_q.push_back({vecs[v].y, vecs[v].g});
            fetch_y_val   = vecs[v].y;
            fetch_x_group = vecs[v].g;
            fetch_en      = 1'b1;
            wait_commit($sformatf("vec%0d", v), 600, n);
            if (vecs[v].exp_n != 0) check($sformatf("vec%0d_latency", v), 32'(n), 32'(vecs[v].exp_n));
            check_addrs($sformatf("vec%0d", v), vecs[v].first, vecs[v].last);
            check($sformatf("vec%0d_pix0", v), 32'(bgr_buf[0]), 32'(vecs[v].pix0));
            check($sformatf("vec%0d_pix31", v), 32'(bgr_buf[31]), 32'(vecs[v].pix31));
            check_commit($sformatf("vec%0d", v), vecs[v].first, vecs[v].abc);
            check($sformatf("vec%0d_overrun", v), 32'(overrun), 32'd0);
            repeat (3) @(negedge clk);
        end

        // Re-requesting the last committed tuple must not refetch
        mem_lat = 1; gnt_toggle = 1'b0; data_abc = 1'b0;
        acc_q.delete();
        fetch_y_val = 9'd100; fetch_x_group = 5'd10; fetch_en = 1'b1;
        commits = 0;
        repeat (40) begin
            @(negedge clk);
            if (buf_commit) commits++;
        end
        fetch_en = 1'b0;
        check("same_tuple_commits", 32'(commits), 32'd0);
        check("same_tuple_reads", 32'(acc_q.size()), 32'd0);

        // New tuple mid-fetch: queued, fetched right after the first commit
        exp_q.push_back({9'd0, 5'd0});
        exp_q.push_back({9'd1, 5'd0});
        pulse_fetch(9'd0, 5'd0);
        repeat (8) @(negedge clk);
        pulse_fetch(9'd1, 5'd0);
        wait_commit("pend1", 200, n);
        check_commit("pend1", 0, 1'b0);
        wait_commit("pend2", 200, n);
        check("pend2_gap", 32'(n), 32'd35);
        check_commit("pend2", 640, 1'b0);
        check("pend_overrun", 32'(overrun), 32'd0);
        repeat (3) @(negedge clk);

        // Two distinct tuples during one fetch: latest wins, overrun sticks
        exp_q.push_back({9'd7, 5'd1});
        exp_q.push_back({9'd9, 5'd3});
        pulse_fetch(9'd7, 5'd1);
        repeat (4) @(negedge clk);
        pulse_fetch(9'd8, 5'd2);
        repeat (4) @(negedge clk);
        pulse_fetch(9'd9, 5'd3);
        check("ovr_set", 32'(overrun), 32'd1);
        wait_commit("ovr1", 200, n);
        check_commit("ovr1", 4512, 1'b0);
        wait_commit("ovr2", 200, n);
        check_commit("ovr2", 5856, 1'b0);
        commits = 0;
        repeat (60) begin
            @(negedge clk);
            if (buf_commit) commits++;
        end
        check("ovr_no_third_commit", 32'(commits), 32'd0);
        check("ovr_sticky", 32'(overrun), 32'd1);

        // Asynchronous reset mid-fetch, then the same tuple fetches again
        acc_q.delete();
        pulse_fetch(9'd4, 5'd4);
        n = 0;
        while (acc_q.size() < 10 && n < 100) begin
            @(negedge clk);
            #2;
            n++;
        end
        check("rst_mid_reached", 32'(acc_q.size() >= 10), 32'd1);
        rst = 1'b0;
        #1;
        check("rstm_req", 32'(mem_rd_req), 32'd0);
        check("rstm_overrun", 32'(overrun), 32'd0);
        check("rstm_buf_y", 32'(buf_y_val), 32'd0);
        check("rstm_buf_x", 32'(buf_x_group), 32'd0);
        check("rstm_state", 32'(fsm_state), 32'(IDLE));
        bad = 0;
        for (int i = 0; i < 32; i++) if (bgr_buf[i] !== 12'h000) bad++;
        check("rstm_bgr_nonzero", 32'(bad), 32'd0);
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        acc_q.delete();
        exp_q.push_back({9'd4, 5'd4});
        fetch_y_val = 9'd4; fetch_x_group = 5'd4; fetch_en = 1'b1;
        wait_commit("refetch", 200, n);
        check("refetch_latency", 32'(n), 32'd35);
        check_addrs("refetch", 2688, 2719);
        check_commit("refetch", 2688, 1'b0);

        check("addr_hold_errors", 32'(hold_err), 32'd0);
        check("outstanding_errors", 32'(ovf_err), 32'd0);
        check("scoreboard_left", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
